// File: rtl/aoi_stimulus_generator.sv
// Clocked stimulus source for the four-input AOI gate: sweeps all 16 {a,b,c,d}
// vectors in binary or Gray order with programmable per-vector hold and sweep repeats.
module aoi_stimulus_generator #(
    parameter int HOLD_W = 8,
    parameter int REP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [REP_W-1:0]  reps,
    input  logic              gray_en,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic [3:0]        vec_idx,
    output logic              vec_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [3:0]         idx_q, idx_d;
    // Terminal counts are stored as max(x,1)-1 so the compare needs no zero special case.
    logic [HOLD_W-1:0]  hold_max_q, hold_max_d;
    logic [REP_W-1:0]   rep_max_q, rep_max_d;
    logic               gray_q, gray_d;
    logic [3:0]         vec_q, vec_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    function automatic logic [3:0] map_vec(input logic [3:0] idx, input logic gray);
        map_vec = gray ? (idx ^ {1'b0, idx[3:1]}) : idx;
    endfunction

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        idx_d      = idx_q;
        hold_max_d = hold_max_q;
        rep_max_d  = rep_max_q;
        gray_d     = gray_q;

        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = {HOLD_W{1'b0}};
                rep_cnt_d  = {REP_W{1'b0}};
                idx_d      = 4'd0;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d    = ST_RUN;
                    hold_max_d = (hold_cycles == {HOLD_W{1'b0}}) ? {HOLD_W{1'b0}}
                                                                 : hold_cycles - HOLD_W'(1);
                    rep_max_d  = (reps == {REP_W{1'b0}}) ? {REP_W{1'b0}}
                                                         : reps - REP_W'(1);
                    gray_d     = gray_en;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = {HOLD_W{1'b0}};
                    rep_cnt_d  = {REP_W{1'b0}};
                    idx_d      = 4'd0;
                end else if (hold_cnt_q == hold_max_q) begin
                    hold_cnt_d = {HOLD_W{1'b0}};
                    if (idx_q == 4'd15) begin
                        idx_d = 4'd0;
                        if (rep_cnt_q == rep_max_q) begin
                            state_d   = ST_DONE;
                            rep_cnt_d = {REP_W{1'b0}};
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                hold_cnt_d = {HOLD_W{1'b0}};
                rep_cnt_d  = {REP_W{1'b0}};
                idx_d      = 4'd0;
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = {HOLD_W{1'b0}};
                rep_cnt_d  = {REP_W{1'b0}};
                idx_d      = 4'd0;
            end
        endcase

        vec_d   = (state_d == ST_RUN) ? map_vec(idx_d, gray_d) : 4'd0;
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    // State, counter, configuration and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= {HOLD_W{1'b0}};
            rep_cnt_q  <= {REP_W{1'b0}};
            idx_q      <= 4'd0;
            hold_max_q <= {HOLD_W{1'b0}};
            rep_max_q  <= {REP_W{1'b0}};
            gray_q     <= 1'b0;
            vec_q      <= 4'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            idx_q      <= idx_d;
            hold_max_q <= hold_max_d;
            rep_max_q  <= rep_max_d;
            gray_q     <= gray_d;
            vec_q      <= vec_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign a         = vec_q[3];
    assign b         = vec_q[2];
    assign c         = vec_q[1];
    assign d         = vec_q[0];
    assign vec_idx   = idx_q;
    assign vec_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aoi_stimulus_generator.sv
// Self-checking bench for aoi_stimulus_generator: directed scenarios plus randomized
// sweeps, compared cycle by cycle against a timeline model of the sweep.
module tb_aoi_stimulus_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] hold_cycles = 8'd0;
    logic [3:0] reps = 4'd0;
    logic       gray_en = 1'b0;
    logic       a, b, c, d;
    logic [3:0] vec_idx;
    logic       vec_valid, busy, done;

    int checks = 0;
    int failures = 0;

    aoi_stimulus_generator #(.HOLD_W(8), .REP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .hold_cycles(hold_cycles), .reps(reps), .gray_en(gray_en),
        .a(a), .b(b), .c(c), .d(d), .vec_idx(vec_idx),
        .vec_valid(vec_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [10:0] obs;
    assign obs = {a, b, c, d, vec_idx, vec_valid, busy, done};

    // Expected {abcd, vec_idx, vec_valid, busy, done} t cycles after the start edge.
    function automatic logic [10:0] model(int t, int h, int r, bit g);
        int hh, rr, total, k, v;
        hh = (h == 0) ? 1 : h;
        rr = (r == 0) ? 1 : r;
        total = 16 * hh * rr;
        if (t < total) begin
            k = (t / hh) % 16;
            v = g ? (k ^ (k / 2)) : k;
            model = {v[3:0], k[3:0], 3'b110};
        end else if (t == total) begin
            model = 11'b00000000_001;
        end else begin
            model = 11'd0;
        end
    endfunction

    function automatic int run_len(int h, int r);
        run_len = 16 * ((h == 0) ? 1 : h) * ((r == 0) ? 1 : r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int h, int r, bit g);
        hold_cycles = 8'(h);
        reps = 4'(r);
        gray_en = g;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs, 11'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_binary_sweep();
        pulse_start(1, 1, 1'b0);
        for (int t = 0; t <= 17; t++) begin
            checks++;
            if (obs !== model(t, 1, 1, 1'b0)) begin
                failures++;
                $display("FAIL binary_sweep t=%0d got=%b exp=%b", t, obs, model(t, 1, 1, 1'b0));
            end
            tick();
        end
    endtask

    task automatic test_gray_hold();
        logic [3:0] prev;
        pulse_start(2, 1, 1'b1);
        prev = 4'd0;
        for (int t = 0; t <= 33; t++) begin
            checks++;
            if (obs !== model(t, 2, 1, 1'b1)) begin
                failures++;
                $display("FAIL gray_hold t=%0d got=%b exp=%b", t, obs, model(t, 2, 1, 1'b1));
            end
            if (t > 0 && t < 32 && (t % 2) == 0) begin
                checks++;
                if ($countones(prev ^ {a, b, c, d}) != 1) begin
                    failures++;
                    $display("FAIL gray_one_bit t=%0d got=%b prev=%b exp=one_bit_change", t, {a, b, c, d}, prev);
                end
            end
            prev = {a, b, c, d};
            tick();
        end
    endtask

    task automatic test_zero_cfg_repeats();
        pulse_start(0, 0, 1'b0);
        for (int t = 0; t <= 17; t++) begin
            checks++;
            if (obs !== model(t, 0, 0, 1'b0)) begin
                failures++;
                $display("FAIL zero_cfg t=%0d got=%b exp=%b", t, obs, model(t, 0, 0, 1'b0));
            end
            tick();
        end
        pulse_start(1, 2, 1'b0);
        for (int t = 0; t <= 33; t++) begin
            checks++;
            if (obs !== model(t, 1, 2, 1'b0)) begin
                failures++;
                $display("FAIL repeats t=%0d got=%b exp=%b", t, obs, model(t, 1, 2, 1'b0));
            end
            tick();
        end
    endtask

    task automatic test_start_ignored();
        pulse_start(1, 1, 1'b1);
        for (int t = 0; t <= 17; t++) begin
            checks++;
            if (obs !== model(t, 1, 1, 1'b1)) begin
                failures++;
                $display("FAIL start_ignored t=%0d got=%b exp=%b", t, obs, model(t, 1, 1, 1'b1));
            end
            start = (t == 5);
            hold_cycles = (t == 5) ? 8'd3 : 8'd1;
            reps = (t == 5) ? 4'd4 : 4'd1;
            gray_en = (t % 2) == 1;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_random_sweeps();
        int h, r, n;
        bit g;
        for (int s = 0; s < 5; s++) begin
            h = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 2));
            g = 1'($urandom_range(0, 1));
            n = run_len(h, r);
            pulse_start(h, r, g);
            for (int t = 0; t <= n + 1; t++) begin
                checks++;
                if (obs !== model(t, h, r, g)) begin
                    failures++;
                    $display("FAIL random_sweep s=%0d t=%0d got=%b exp=%b", s, t, obs, model(t, h, r, g));
                end
                hold_cycles = 8'($urandom);
                reps = 4'($urandom);
                gray_en = 1'($urandom);
                tick();
            end
        end
    endtask

    task automatic test_stop();
        pulse_start(1, 1, 1'b0);
        for (int t = 0; t <= 7; t++) begin
            checks++;
            if (obs !== model(t, 1, 1, 1'b0)) begin
                failures++;
                $display("FAIL stop_pre t=%0d got=%b exp=%b", t, obs, model(t, 1, 1, 1'b0));
            end
            stop = (t == 7);
            tick();
        end
        stop = 1'b0;
        for (int t = 0; t < 12; t++) begin
            checks++;
            if (obs !== 11'd0) begin
                failures++;
                $display("FAIL stop_idle t=%0d got=%b exp=%b", t, obs, 11'd0);
            end
            tick();
        end
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (obs !== 11'd0) begin
                failures++;
                $display("FAIL start_stop_idle t=%0d got=%b exp=%b", t, obs, 11'd0);
            end
            tick();
        end
    endtask

    task automatic test_reset_midrun();
        pulse_start(1, 1, 1'b0);
        for (int t = 0; t <= 9; t++) begin
            checks++;
            if (obs !== model(t, 1, 1, 1'b0)) begin
                failures++;
                $display("FAIL rst_pre t=%0d got=%b exp=%b", t, obs, model(t, 1, 1, 1'b0));
            end
            if (t < 9) tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL rst_async got=%b exp=%b", obs, 11'd0);
        end
        tick();
        rst = 1'b0;
        pulse_start(1, 1, 1'b1);
        for (int t = 0; t <= 17; t++) begin
            checks++;
            if (obs !== model(t, 1, 1, 1'b1)) begin
                failures++;
                $display("FAIL rst_restart t=%0d got=%b exp=%b", t, obs, model(t, 1, 1, 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(1, 1, 1'b0);
        for (int t = 0; t <= 16; t++) begin
            checks++;
            if (obs !== model(t, 1, 1, 1'b0)) begin
                failures++;
                $display("FAIL b2b_first t=%0d got=%b exp=%b", t, obs, model(t, 1, 1, 1'b0));
            end
            if (t == 16) begin
                hold_cycles = 8'd2;
                reps = 4'd1;
                gray_en = 1'b1;
                start = 1'b1;
            end
            tick();
        end
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL b2b_idle_gap got=%b exp=%b", obs, 11'd0);
        end
        tick();
        start = 1'b0;
        for (int t = 0; t <= 33; t++) begin
            checks++;
            if (obs !== model(t, 2, 1, 1'b1)) begin
                failures++;
                $display("FAIL b2b_second t=%0d got=%b exp=%b", t, obs, model(t, 2, 1, 1'b1));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_binary_sweep();
        test_gray_hold();
        test_zero_cfg_repeats();
        test_start_ignored();
        test_random_sweeps();
        test_stop();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aoi_stimulus_generator.md
# aoi_stimulus_generator

Sequential vector source that sits directly upstream of the four-input AOI gate and drives its `a`, `b`, `c`, `d` inputs. It replaces free-running toggle stimulus with a clocked, programmable sweep of all 16 input combinations. Each vector is held for a programmable number of cycles, and the full sweep repeats a programmable number of times. A start/busy/done handshake lets a bench or a downstream checker align to every vector.

## Interface
- `HOLD_W`, default 8: width of the per-vector hold count.
- `REP_W`, default 4: width of the sweep repeat count.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `stop`  in  1  synchronous abort; returns to IDLE from any state.
- `hold_cycles`  in  HOLD_W  cycles each vector is held; latched on accepted start; 0 is treated as 1.
- `reps`  in  REP_W  number of full 16-vector sweeps; latched on accepted start; 0 is treated as 1.
- `gray_en`  in  1  1 = Gray-code order, 0 = binary order; latched on accepted start.
- `a`, `b`, `c`, `d`  out  1 each  gate inputs; `{a,b,c,d}` is the current vector, with `a` as the MSB.
- `vec_idx`  out  4  index of the current vector, 0..15.
- `vec_valid`  out  1  high while a vector is being driven.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a sweep set completes normally.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - Outputs: `a`..`d`=0, `vec_idx`=0, `vec_valid`=0, `busy`=0, `done`=0.
  - `start`=1 and `stop`=0: latch the configuration, clear the hold counter, set `vec_idx`=0 and rep counter=0, then go to RUN.
- **RUN:**
  - `vec_valid`=1, `busy`=1.
  - Vector mapping: `{a,b,c,d}` = `vec_idx` when `gray_en`=0, or `vec_idx ^ (vec_idx >> 1)` when `gray_en`=1.
  - The hold counter counts 0..H-1, where H = max(`hold_cycles`,1).
  - When the hold counter reaches H-1, it resets to 0 and `vec_idx` increments, wrapping 15→0.
  - On the 15→0 wrap, the rep counter increments.
  - If the rep counter reaches R = max(`reps`,1), go to DONE instead of wrapping.
- **DONE:**
  - Lasts one cycle: `done`=1, `busy`=0, `vec_valid`=0, `a`..`d`=0.
  - Then go to IDLE.
- **Start handling:** `start` is ignored in RUN and DONE. Configuration inputs are ignored except on an accepted start.
- **Stop handling:**
  - `stop`=1 in any state: next state IDLE, counters cleared, no `done` pulse.
  - `stop` and `start` together in IDLE: stop wins and the state stays IDLE.
- **Counter widths:** hold counter is HOLD_W bits; rep counter is REP_W bits. No overflow is possible because the terminal compare comes before the increment.
- **Reset:** `rst` asserted at any time, including mid-sweep, forces IDLE and the IDLE output values immediately (asynchronously). Latched configuration is cleared to 0.

## Timing
- **Start latency:** `start` sampled high at edge N. From edge N+1, `vec_idx`=0 is driven with `vec_valid`=1 and `busy`=1.
- **Vector cadence:** vector k is driven for exactly H cycles, over edges N+1+k·H through N+(k+1)·H.
- **Run length:** RUN lasts exactly 16·H·R cycles.
- **Done pulse:** `done` is high for the single cycle following the last RUN cycle.
- **Back-to-back starts:** IDLE is reached one cycle after DONE, so a new `start` is accepted at the earliest 2 cycles after the final vector ends.
- **Output registration:** all outputs are registered, with no combinational path from inputs to outputs.
- **Stop latency:** `stop` sampled at edge M gives IDLE outputs from edge M+1.
- **Reset release:** the first `start` is accepted at the first clock edge where `rst`=0.

## Test plan
- **Binary sweep:** `rst` pulse, then `start` with H=1, R=1, `gray_en`=0 → `{a,b,c,d}` = 0000, 0001, …, 1111 on 16 consecutive cycles; `done`=1 on cycle 17; `busy` low from cycle 17.
- **Gray sweep with hold:** H=2, R=1, `gray_en`=1 → each vector lasts 2 cycles, sequence 0000, 0001, 0011, 0010, 0110, …, 1000; exactly 1 bit changes per step; `done` after 32 RUN cycles.
- **Zero config and repeats:** `hold_cycles`=0, `reps`=0 → behaves as H=1, R=1 (16 cycles). Then `reps`=2, H=1 → 32 vectors, `vec_idx` wraps 15→0 once, with no `done` at the wrap.
- **Start ignored while busy:** `start` re-asserted at `vec_idx`=5 → sweep continues unchanged and the configuration is not re-latched; latched `gray_en` persists even when the input toggles mid-run.
- **Stop mid-run:** `stop` at `vec_idx`=7 → IDLE next cycle, all outputs 0, no `done` pulse. Simultaneous `start`+`stop` in IDLE → stays IDLE.
- **Reset mid-run:** `rst` asserted between edges at `vec_idx`=9 → outputs go to 0 immediately without waiting for a clock edge. After release, a new `start` produces 0000 first.
